// File: rtl/e1_rx_hdb3_dec_pkg.sv
// ----------------------------------------------------------------------------
// e1_rx_hdb3_dec_pkg
//   Shared constants and helpers for the E1 receive HDB3 decoder and the
//   E1 loss-of-signal detector.
//   Contents:
//     E1_HDB3_LAT         decoder latency in bit periods (depth of the
//                         substitution-removal shift register)
//     E1_LOS_THRESH_DFLT  default number of consecutive no-pulse symbols
//                         before loss of signal is declared
//     sym_t / decode_sym  classification of one (hi, lo) line sample
// ----------------------------------------------------------------------------
package e1_rx_hdb3_dec_pkg;

  localparam int E1_HDB3_LAT        = 4;
  localparam int E1_LOS_THRESH_DFLT = 32;

  // One received line symbol after classification.
  typedef struct packed {
    logic pulse;  // a single-polarity mark was seen
    logic pol;    // 1 = positive, 0 = negative (only meaningful with pulse)
    logic both;   // both rails high: illegal, decoded as no pulse
  } sym_t;

  function automatic sym_t decode_sym(input logic hi, input logic lo);
    sym_t s;
    s.pulse = hi ^ lo;
    s.pol   = hi;
    s.both  = hi & lo;
    return s;
  endfunction

endpackage

// File: rtl/e1_rx_los_det.sv
// ----------------------------------------------------------------------------
// e1_rx_los_det
//   Loss-of-signal detector for the E1 receive path. Counts consecutive
//   symbols without a pulse (8-bit, saturating at 255) and raises los once
//   the run reaches THRESH. Any pulse clears the run and los on that strobe.
//   Also reused by the framer LOS logic.
//   Parameters:
//     THRESH  run length that asserts los (valid 4..255)
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     stb    in  one-cycle symbol strobe
//     pulse  in  current symbol carries a pulse (valid with stb)
//     los    out loss of signal level
// ----------------------------------------------------------------------------
module e1_rx_los_det
  import e1_rx_hdb3_dec_pkg::*;
#(
  parameter int THRESH = E1_LOS_THRESH_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic pulse,
  output logic los
);

  localparam logic [7:0] LOS_THR = 8'(THRESH);

  logic [7:0] r_run;
  logic       r_los;
  logic [7:0] w_run_inc;

  // The run counter sticks at 255 so a very long silence can never wrap
  // back below the threshold and drop los by accident.
  assign w_run_inc = (r_run == 8'hFF) ? 8'hFF : r_run + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= '0;
      r_los <= 1'b0;
    end else if (stb) begin
      if (pulse) begin
        r_run <= '0;
        r_los <= 1'b0;
      end else begin
        r_run <= w_run_inc;
        r_los <= (w_run_inc >= LOS_THR);
      end
    end
  end

  assign los = r_los;

endmodule

// File: rtl/e1_rx_hdb3_dec.sv
// ----------------------------------------------------------------------------
// e1_rx_hdb3_dec
//   HDB3 line decoder for the E1 receive path. Consumes per-bit (hi, lo, stb)
//   samples from clock recovery, removes B00V / 000V substitutions and emits
//   NRZ data with a fixed latency of E1_HDB3_LAT bit periods. Detects code
//   errors (both rails high, or two successive violations of the same
//   polarity) and keeps a saturating error count.
//   Optional feature: define E1_RX_HDB3_LOS_EN to include the loss-of-signal
//   detector (e1_rx_los_det); otherwise los is tied low.
//   Parameters:
//     ERR_W       width of the saturating code-error counter
//     LOS_THRESH  consecutive no-pulse symbols before los asserts (4..255)
//   Ports:
//     clk       in  system clock
//     rst_n     in  asynchronous active-low reset
//     in_hi     in  positive-pulse sample (valid with in_stb)
//     in_lo     in  negative-pulse sample (valid with in_stb)
//     in_stb    in  one-cycle bit strobe
//     out_data  out decoded NRZ bit (valid with out_stb)
//     out_stb   out one-cycle strobe, one clk after in_stb
//     err_stb   out code-error pulse, coincident with out_stb
//     err_cnt   out saturating code-error count
//     err_clr   in  synchronous clear of err_cnt
//     los       out loss of signal level
// ----------------------------------------------------------------------------
module e1_rx_hdb3_dec
  import e1_rx_hdb3_dec_pkg::*;
#(
  parameter int ERR_W      = 16,
  parameter int LOS_THRESH = E1_LOS_THRESH_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_hi,
  input  logic             in_lo,
  input  logic             in_stb,
  output logic             out_data,
  output logic             out_stb,
  output logic             err_stb,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             los
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  logic [E1_HDB3_LAT-1:0] r_sr;
  logic                   r_last_pol;
  logic                   r_have_pulse;
  logic                   r_have_v;
  logic                   r_last_vpol;
  logic                   r_out_data;
  logic                   r_out_stb;
  logic                   r_err_stb;
  logic [ERR_W-1:0]       r_err_cnt;

  sym_t                   w_sym;
  logic                   w_is_v;
  logic                   w_err;

  assign w_sym  = decode_sym(in_hi, in_lo);

  // A violation repeats the polarity of the previous mark; it can only be
  // recognised once at least one mark has been seen since reset.
  assign w_is_v = w_sym.pulse & r_have_pulse & (w_sym.pol == r_last_pol);

  assign w_err  = in_stb & (w_sym.both |
                            (w_is_v & r_have_v & (w_sym.pol == r_last_vpol)));

  // Substitution removal: each symbol walks through a 4-deep shift register
  // before it is emitted. A violation clears the register, which blanks the
  // V and the three symbols before it -- exactly the span of both B00V and
  // 000V -- while the oldest symbol has already been taken out this strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr         <= '0;
      r_last_pol   <= 1'b0;
      r_have_pulse <= 1'b0;
      r_have_v     <= 1'b0;
      r_last_vpol  <= 1'b0;
      r_out_data   <= 1'b0;
    end else if (in_stb) begin
      r_out_data <= r_sr[E1_HDB3_LAT-1];
      if (w_is_v) begin
        r_sr        <= '0;
        r_have_v    <= 1'b1;
        r_last_vpol <= w_sym.pol;
      end else begin
        r_sr <= {r_sr[E1_HDB3_LAT-2:0], w_sym.pulse};
      end
      if (w_sym.pulse) begin
        r_last_pol   <= w_sym.pol;
        r_have_pulse <= 1'b1;
      end
    end
  end

  // Output strobes are registered copies of the input strobe so that data
  // and error flag appear together one clock after the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_stb <= 1'b0;
      r_err_stb <= 1'b0;
    end else begin
      r_out_stb <= in_stb;
      r_err_stb <= w_err;
    end
  end

  // Error counter: a clear that coincides with an error keeps that error,
  // and the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= w_err ? ERR_W'(1) : '0;
    end else if (w_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign out_data = r_out_data;
  assign out_stb  = r_out_stb;
  assign err_stb  = r_err_stb;
  assign err_cnt  = r_err_cnt;

`ifdef E1_RX_HDB3_LOS_EN
  e1_rx_los_det #(
    .THRESH (LOS_THRESH)
  ) u_los_det (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (in_stb),
    .pulse (w_sym.pulse),
    .los   (los)
  );
`else
  assign los = 1'b0;
`endif

endmodule

// File: tb/tb_e1_rx_hdb3_dec.sv
// ----------------------------------------------------------------------------
// tb_e1_rx_hdb3_dec
//   Scoreboard bench for e1_rx_hdb3_dec. The driver computes the expected
//   response of every strobed symbol from the HDB3 rules (symbol history
//   queues, blanking spans around violations) and queues it; a monitor pops
//   and compares on each out_stb. Honours E1_RX_HDB3_LOS_EN like the design.
// ----------------------------------------------------------------------------
module tb_e1_rx_hdb3_dec;

  localparam int LAT    = 4;
  localparam int THRESH = 32;
`ifdef E1_RX_HDB3_LOS_EN
  localparam bit LOS_ON = 1'b1;
`else
  localparam bit LOS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_hi = 1'b0;
  logic        in_lo = 1'b0;
  logic        in_stb = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_data;
  logic        out_stb;
  logic        err_stb;
  logic [15:0] err_cnt;
  logic        los;

  e1_rx_hdb3_dec #(
    .ERR_W      (16),
    .LOS_THRESH (THRESH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_hi    (in_hi),
    .in_lo    (in_lo),
    .in_stb   (in_stb),
    .out_data (out_data),
    .out_stb  (out_stb),
    .err_stb  (err_stb),
    .err_cnt  (err_cnt),
    .err_clr  (err_clr),
    .los      (los)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        data;
    logic        err;
    logic [15:0] cnt;
    logic        los;
  } exp_t;

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;

  // Reference model state, described in terms of symbol history.
  bit   decoded[$];
  bit   pulseHist[$];
  bit   vHist[$];
  int   symIdx;
  int   modelCnt;
  int   zeroRun;
  bit   modelLos;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    decoded.delete();
    pulseHist.delete();
    vHist.delete();
    expQ.delete();
    symIdx   = 0;
    modelCnt = 0;
    zeroRun  = 0;
    modelLos = 1'b0;
  endtask

  // Drive one cycle of inputs, update the model and queue the expectation.
  task automatic applyStimulus(input bit hi, input bit lo, input bit stb, input bit clr);
    bit   isPulse;
    bit   isV;
    bit   errNow;
    exp_t e;
    in_hi   = hi;
    in_lo   = lo;
    in_stb  = stb;
    err_clr = clr;
    errNow  = 1'b0;
    e.data  = 1'b0;
    if (stb) begin
      isPulse = hi ^ lo;
      isV     = 1'b0;
      e.data  = (symIdx >= LAT) ? decoded[symIdx-LAT] : 1'b0;
      if (isPulse) begin
        isV = (pulseHist.size() > 0) && (pulseHist[$] == hi);
        if (isV) begin
          if ((vHist.size() > 0) && (vHist[$] == hi)) errNow = 1'b1;
          vHist.push_back(hi);
        end
        pulseHist.push_back(hi);
      end
      if (hi && lo) errNow = 1'b1;
      decoded.push_back(isPulse);
      if (isV) begin
        for (int j = symIdx - 3; j <= symIdx; j++)
          if (j >= 0) decoded[j] = 1'b0;
      end
      symIdx++;
      if (isPulse) zeroRun = 0;
      else if (zeroRun < 255) zeroRun++;
      modelLos = LOS_ON && !isPulse && (zeroRun >= THRESH);
    end
    if (clr) modelCnt = errNow ? 1 : 0;
    else if (errNow && modelCnt < 65535) modelCnt++;
    if (stb) begin
      e.err = errNow;
      e.cnt = 16'(modelCnt);
      e.los = modelLos;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendP(); applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic sendN(); applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); endtask
  task automatic sendZ(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); endtask

  task automatic waitDrain();
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    while (expQ.size() != 0 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (expQ.size() != 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d outputs missing, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_stb) begin
      if (expQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpected_out_stb: got out_stb=1 expected no output at %0t", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("err_stb", 32'(err_stb), 32'(e.err));
        checkOutput("err_cnt", 32'(err_cnt), 32'(e.cnt));
        checkOutput("los", 32'(los), 32'(e.los));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_data", 32'(out_data), 0);
    checkOutput("reset_out_stb", 32'(out_stb), 0);
    checkOutput("reset_err_stb", 32'(err_stb), 0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 0);
    checkOutput("reset_los", 32'(los), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Alternating marks: four zeros of latency then ones.
    for (int i = 0; i < 4; i++) begin sendP(); sendN(); end
    for (int i = 0; i < 4; i++) sendZ();
    waitDrain();
    checkOutput("t1_err_cnt", 32'(err_cnt), 0);

    // 000V after a positive mark, then a negative mark.
    doReset();
    sendP(); sendZ(); sendZ(); sendZ(); sendP(); sendN();
    for (int i = 0; i < 4; i++) sendZ();
    waitDrain();
    checkOutput("t2_err_cnt", 32'(err_cnt), 0);

    // B00V with alternating violation polarity.
    doReset();
    sendP(); sendZ(); sendZ(); sendZ(); sendP();
    sendN(); sendP();
    sendN(); sendZ(); sendZ(); sendN();
    sendP();
    for (int i = 0; i < 4; i++) sendZ();
    waitDrain();
    checkOutput("t3_err_cnt", 32'(err_cnt), 0);

    // Same-polarity violations, both-rails error, clear with error.
    doReset();
    sendP(); sendZ(); sendZ(); sendZ(); sendP();
    sendN(); sendP(); sendZ(); sendZ(); sendP();
    waitDrain();
    checkOutput("t4_same_v", 32'(err_cnt), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitDrain();
    checkOutput("t4_both", 32'(err_cnt), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    waitDrain();
    checkOutput("t4_clr_err", 32'(err_cnt), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_clr", 32'(err_cnt), 0);

    // Saturation of the error counter.
    for (int i = 0; i < 65536 + 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    waitDrain();
    checkOutput("t4_sat", 32'(err_cnt), 32'h0000_FFFF);

    // Loss-of-signal threshold.
    doReset();
    sendP();
    for (int i = 0; i < THRESH - 1; i++) sendZ();
    waitDrain();
    checkOutput("t5_los_31", 32'(los), 0);
    sendZ();
    waitDrain();
    checkOutput("t5_los_32", 32'(los), 32'(LOS_ON));
    sendN();
    waitDrain();
    checkOutput("t5_los_mark", 32'(los), 0);

    // Reset mid-stream with state loaded.
    doReset();
    sendP(); sendN(); sendP(); applyStimulus(1'b1, 1'b1, 1'b1, 1'b0); sendN(); sendP();
    waitDrain();
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_data", 32'(out_data), 0);
    checkOutput("t6_rst_out_stb", 32'(out_stb), 0);
    checkOutput("t6_rst_err_cnt", 32'(err_cnt), 0);
    checkOutput("t6_rst_los", 32'(los), 0);
    modelReset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendP();
    for (int i = 0; i < 4; i++) sendZ();
    waitDrain();
    checkOutput("t6_post_err_cnt", 32'(err_cnt), 0);

    // Randomised symbol streams with gaps and occasional clears.
    for (int round = 0; round < 3; round++) begin
      bit lastPol;
      doReset();
      lastPol = 1'b0;
      for (int i = 0; i < 300; i++) begin
        int r;
        bit clr;
        r   = $urandom_range(0, 99);
        clr = ($urandom_range(0, 99) < 3);
        if (r < 40) begin
          lastPol = ~lastPol;
          applyStimulus(lastPol, ~lastPol, 1'b1, clr);
        end else if (r < 75) begin
          applyStimulus(1'b0, 1'b0, 1'b1, clr);
        end else if (r < 95) begin
          applyStimulus(lastPol, ~lastPol, 1'b1, clr);
        end else begin
          applyStimulus(1'b1, 1'b1, 1'b1, clr);
        end
        if ($urandom_range(0, 3) == 0)
          applyStimulus(1'b0, 1'b0, 1'b0, ($urandom_range(0, 49) == 0));
      end
      waitDrain();
      checkOutput("rand_err_cnt", 32'(err_cnt), 32'(modelCnt));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
